// File: rtl/umtrx_tx_dac_mux.sv
// UmTRX TX DAC mux: per-channel sample FIFOs with prime/run/underrun sequencing
// that feed strobe-paced, registered DAC words.

module umtrx_tx_dac_chan #(
    parameter int DAC_WIDTH  = 12,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 run,
    input  logic                 swap,
    input  logic                 neg,
    input  logic                 clr,
    input  logic                 dac_stb,
    input  logic [31:0]          in_tdata,
    input  logic                 in_tvalid,
    output logic                 in_tready,
    output logic [DAC_WIDTH-1:0] dac_i,
    output logic [DAC_WIDTH-1:0] dac_q,
    output logic                 underflow,
    output logic [15:0]          uflow_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, UNDERRUN} state_t;

    state_t                state_q, state_d;
    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic [DAC_WIDTH-1:0]  dac_i_q, dac_i_d, dac_q_q, dac_q_d;
    logic                  uf_q, uf_d;
    logic [15:0]           ucnt_q, ucnt_d;
    logic [31:0]           head;
    logic [15:0]           q_src, s_i, s_q;
    logic                  kill, full, empty, push, pop;

    assign kill      = !(run && en);
    assign full      = (cnt_q == FULL_CNT);
    assign empty     = (cnt_q == '0);
    assign in_tready = !full && (state_q != IDLE);
    assign push      = in_tvalid && in_tready;
    assign pop       = dac_stb && (state_q == RUN) && !empty;
    assign head      = mem_q[rd_ptr_q];

    // Negate acts on the incoming Q field, then swap exchanges the lanes.
    always_comb begin
        q_src = head[15:0];
        if (neg) q_src = (head[15:0] == 16'h8000) ? 16'h7FFF : 16'd0 - head[15:0];
        s_i = swap ? q_src : head[31:16];
        s_q = swap ? head[31:16] : q_src;
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dac_i_d  = dac_i_q;
        dac_q_d  = dac_q_q;
        uf_d     = dac_stb && (state_q == RUN) && empty;
        ucnt_d   = ucnt_q;
        if (uf_d && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
        if (clr) ucnt_d = '0;
        if (dac_stb) begin
            dac_i_d = pop ? DAC_WIDTH'(s_i >> (16 - DAC_WIDTH)) : '0;
            dac_q_d = pop ? DAC_WIDTH'(s_q >> (16 - DAC_WIDTH)) : '0;
        end
        if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (DEPTH_LOG2+1)'(1);
            2'b01:   cnt_d = cnt_q - (DEPTH_LOG2+1)'(1);
            default: ;
        endcase
        case (state_q)
            IDLE:     state_d = PRIME;
            PRIME:    if (full) state_d = RUN;
            RUN:      if (uf_d) state_d = UNDERRUN;
            UNDERRUN: state_d = PRIME;
            default:  state_d = IDLE;
        endcase
        // Dropping run or enable flushes the FIFO on the same edge.
        if (kill) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dac_i_q  <= '0;
            dac_q_q  <= '0;
            uf_q     <= 1'b0;
            ucnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dac_i_q  <= dac_i_d;
            dac_q_q  <= dac_q_d;
            uf_q     <= uf_d;
            ucnt_q   <= ucnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_tdata;
    end

    assign dac_i       = dac_i_q;
    assign dac_q       = dac_q_q;
    assign underflow   = uf_q;
    assign uflow_count = ucnt_q;
endmodule

module umtrx_tx_dac_mux #(
    parameter int NCHAN      = 2,
    parameter int DAC_WIDTH  = 12,
    parameter int DEPTH_LOG2 = 2,
    parameter int BASE       = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       set_stb,
    input  logic [7:0]                 set_addr,
    input  logic [31:0]                set_data,
    input  logic [NCHAN*32-1:0]        in_tdata,
    input  logic [NCHAN-1:0]           in_tvalid,
    output logic [NCHAN-1:0]           in_tready,
    input  logic [NCHAN-1:0]           run,
    input  logic                       dac_stb,
    output logic [NCHAN*DAC_WIDTH-1:0] dac_i,
    output logic [NCHAN*DAC_WIDTH-1:0] dac_q,
    output logic                       dac_valid,
    output logic [NCHAN-1:0]           underflow,
    output logic [NCHAN*16-1:0]        uflow_count
);
    localparam logic [7:0] ADDR_CTRL = 8'(BASE);
    localparam logic [7:0] ADDR_CLR  = 8'(BASE + 1);

    logic [NCHAN-1:0] en_q;
    logic             swap_q, neg_q, dac_valid_q;
    logic             clr;
    logic             unused_set_bits;

    assign clr             = set_stb && (set_addr == ADDR_CLR);
    assign unused_set_bits = ^{set_data[31:10], set_data[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q        <= '0;
            swap_q      <= 1'b0;
            neg_q       <= 1'b0;
            dac_valid_q <= 1'b0;
        end else begin
            dac_valid_q <= dac_stb;
            if (set_stb && set_addr == ADDR_CTRL) begin
                en_q   <= set_data[NCHAN-1:0];
                swap_q <= set_data[8];
                neg_q  <= set_data[9];
            end
        end
    end

    assign dac_valid = dac_valid_q;

    for (genvar n = 0; n < NCHAN; n++) begin : g_chan
        umtrx_tx_dac_chan #(
            .DAC_WIDTH (DAC_WIDTH),
            .DEPTH_LOG2(DEPTH_LOG2)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en         (en_q[n]),
            .run        (run[n]),
            .swap       (swap_q),
            .neg        (neg_q),
            .clr        (clr),
            .dac_stb    (dac_stb),
            .in_tdata   (in_tdata[32*n +: 32]),
            .in_tvalid  (in_tvalid[n]),
            .in_tready  (in_tready[n]),
            .dac_i      (dac_i[DAC_WIDTH*n +: DAC_WIDTH]),
            .dac_q      (dac_q[DAC_WIDTH*n +: DAC_WIDTH]),
            .underflow  (underflow[n]),
            .uflow_count(uflow_count[16*n +: 16])
        );
    end
endmodule

// File: tb/tb_umtrx_tx_dac_mux.sv
// Bench for umtrx_tx_dac_mux: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a queue-based channel model.

module tb_umtrx_tx_dac_mux;
    localparam int NCHAN  = 2;
    localparam int DW     = 12;
    localparam int DL     = 2;
    localparam int DEPTH  = 1 << DL;
    localparam int BASE_A = 'h20;
    localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_UNDER = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                set_stb = 1'b0;
    logic [7:0]          set_addr = '0;
    logic [31:0]         set_data = '0;
    logic [NCHAN*32-1:0] in_tdata = '0;
    logic [NCHAN-1:0]    in_tvalid = '0;
    logic [NCHAN-1:0]    in_tready;
    logic [NCHAN-1:0]    run = '0;
    logic                dac_stb = 1'b0;
    logic [NCHAN*DW-1:0] dac_i, dac_q;
    logic                dac_valid;
    logic [NCHAN-1:0]    underflow;
    logic [NCHAN*16-1:0] uflow_count;

    int n_cmp = 0;
    int n_bad = 0;

    umtrx_tx_dac_mux #(.NCHAN(NCHAN), .DAC_WIDTH(DW), .DEPTH_LOG2(DL), .BASE(BASE_A)) dut (
        .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready), .run(run),
        .dac_stb(dac_stb), .dac_i(dac_i), .dac_q(dac_q), .dac_valid(dac_valid),
        .underflow(underflow), .uflow_count(uflow_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference model: one sample queue and a mode number per channel.
    logic [31:0]      mq [NCHAN][$];
    int               mmode [NCHAN];
    logic [NCHAN-1:0] m_en;
    logic             m_swap, m_neg;
    logic [DW-1:0]    e_i [NCHAN];
    logic [DW-1:0]    e_q [NCHAN];
    logic [15:0]      e_cnt [NCHAN];
    logic [NCHAN-1:0] e_uf;
    logic             e_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_rdy(input int n);
        return mmode[n] != M_IDLE && mq[n].size() < DEPTH;
    endfunction

    function automatic logic [2*DW-1:0] xform(input logic [31:0] w);
        int si, sq, t;
        si = int'($signed(w[31:16]));
        sq = int'($signed(w[15:0]));
        if (m_neg) sq = (sq == -32768) ? 32767 : -sq;
        if (m_swap) begin t = si; si = sq; sq = t; end
        return {DW'(si >>> (16 - DW)), DW'(sq >>> (16 - DW))};
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NCHAN; n++) begin
            mq[n].delete();
            mmode[n] = M_IDLE;
            e_i[n] = '0;
            e_q[n] = '0;
            e_cnt[n] = '0;
        end
        m_en = '0; m_swap = 1'b0; m_neg = 1'b0; e_uf = '0; e_valid = 1'b0;
    endtask

    task automatic model_edge();
        bit clr;
        logic [2*DW-1:0] x;
        clr = set_stb && set_addr == 8'(BASE_A + 1);
        e_valid = dac_stb;
        for (int n = 0; n < NCHAN; n++) begin
            bit kill, push, was_full;
            kill = !(run[n] && m_en[n]);
            push = in_tvalid[n] && m_rdy(n);
            was_full = mq[n].size() == DEPTH;
            e_uf[n] = 1'b0;
            if (dac_stb) begin
                if (mmode[n] == M_RUN && mq[n].size() > 0) begin
                    x = xform(mq[n].pop_front());
                    e_i[n] = x[2*DW-1:DW];
                    e_q[n] = x[DW-1:0];
                end else begin
                    e_i[n] = '0;
                    e_q[n] = '0;
                    if (mmode[n] == M_RUN) begin
                        e_uf[n] = 1'b1;
                        if (e_cnt[n] != 16'hFFFF) e_cnt[n] = e_cnt[n] + 16'd1;
                    end
                end
            end
            if (clr) e_cnt[n] = '0;
            if (kill) begin
                mq[n].delete();
                mmode[n] = M_IDLE;
            end else begin
                if (push) mq[n].push_back(in_tdata[32*n +: 32]);
                case (mmode[n])
                    M_IDLE:  mmode[n] = M_PRIME;
                    M_PRIME: if (was_full) mmode[n] = M_RUN;
                    M_RUN:   if (e_uf[n]) mmode[n] = M_UNDER;
                    default: mmode[n] = M_PRIME;
                endcase
            end
        end
        if (set_stb && set_addr == 8'(BASE_A)) begin
            m_en = set_data[NCHAN-1:0];
            m_swap = set_data[8];
            m_neg = set_data[9];
        end
    endtask

    task automatic check_all();
        logic [NCHAN*DW-1:0] pi, pq;
        logic [NCHAN*16-1:0] pc;
        logic [NCHAN-1:0]    pr;
        for (int n = 0; n < NCHAN; n++) begin
            pi[DW*n +: DW] = e_i[n];
            pq[DW*n +: DW] = e_q[n];
            pc[16*n +: 16] = e_cnt[n];
            pr[n] = m_rdy(n);
        end
        chk("dac_i", dac_i, pi);
        chk("dac_q", dac_q, pq);
        chk("dac_valid", dac_valid, e_valid);
        chk("underflow", underflow, e_uf);
        chk("uflow_count", uflow_count, pc);
        chk("in_tready", in_tready, pr);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dac_i"}, dac_i, 64'd0);
        chk({tag, "_dac_q"}, dac_q, 64'd0);
        chk({tag, "_valid"}, dac_valid, 64'd0);
        chk({tag, "_uf"}, underflow, 64'd0);
        chk({tag, "_cnt"}, uflow_count, 64'd0);
        chk({tag, "_rdy"}, in_tready, 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
        check_all();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        step();
        set_stb = 1'b0;
    endtask

    task automatic stb_step();
        dac_stb = 1'b1;
        step();
        dac_stb = 1'b0;
    endtask

    task automatic fill(input int n, input logic [31:0] d, input int cnt);
        int got;
        got = 0;
        in_tdata[32*n +: 32] = d;
        for (int k = 0; k < 20 && got < cnt; k++) begin
            in_tvalid[n] = 1'b1;
            if (m_rdy(n)) got++;
            step();
        end
        in_tvalid[n] = 1'b0;
        chk("fill_count", got, cnt);
    endtask

    int uf0, uf1, pv0, pv1, ps, r, k;

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1 chk_zero("rst");
        step(); step();
        rst = 1'b0;
        run = '1;
        repeat (3) step();
        chk("no_enable_ready", in_tready, 64'd0);

        // Prime, run, first sample
        wr(8'(BASE_A), 32'h3);
        fill(0, 32'h7FF0_8000, 4);
        step(); step();
        stb_step();
        chk("prime_dac_i0", dac_i[DW-1:0], 12'h7FF);
        chk("prime_dac_q0", dac_q[DW-1:0], 12'h800);
        chk("prime_valid", dac_valid, 1);

        // Drain into an underrun
        uf0 = 0;
        for (int c = 0; c < 40; c++) begin
            dac_stb = (c % 4 == 0);
            step();
            if (underflow[0]) uf0++;
        end
        dac_stb = 1'b0;
        chk("underrun_pulses", uf0, 1);
        chk("underrun_count0", uflow_count[15:0], 1);
        chk("underrun_dac_i0", dac_i[DW-1:0], 0);

        // Re-prime, stream one, then drop run with three entries queued
        fill(0, 32'hA5A5_5A5A, 4);
        step(); step();
        stb_step();
        run[0] = 1'b0;
        step();
        chk("drop_ready0", in_tready[0], 0);
        stb_step();
        chk("drop_dac_i0", dac_i[DW-1:0], 0);
        chk("drop_uf", underflow, 0);
        run[0] = 1'b1;
        step();

        // Swap and negate, then a clear colliding with an underrun
        wr(8'(BASE_A), 32'h301);
        fill(0, 32'h1234_8000, 4);
        step(); step();
        stb_step();
        chk("swapneg_i", dac_i[DW-1:0], 12'h7FF);
        chk("swapneg_q", dac_q[DW-1:0], 12'h123);
        for (int c = 0; c < 3; c++) begin step(); stb_step(); end
        set_stb = 1'b1; set_addr = 8'(BASE_A + 1); dac_stb = 1'b1;
        step();
        set_stb = 1'b0; dac_stb = 1'b0;
        chk("clr_uf_pulse", underflow[0], 1);
        chk("clr_wins", uflow_count[15:0], 0);

        // ch1 underruns while ch0 keeps streaming
        wr(8'(BASE_A), 32'h3);
        fill(0, $urandom, 4);
        fill(1, $urandom, 4);
        step(); step();
        uf0 = 0; uf1 = 0;
        for (int c = 0; c < 40; c++) begin
            in_tdata[31:0] = $urandom;
            in_tvalid[0] = 1'b1;
            dac_stb = (c % 3 == 0);
            step();
            if (underflow[0]) uf0++;
            if (underflow[1]) uf1++;
        end
        in_tvalid = '0; dac_stb = 1'b0;
        chk("conc_uf0", uf0, 0);
        chk("conc_uf1", uf1, 1);

        // Randomized traffic
        for (int seg = 0; seg < 30; seg++) begin
            pv0 = $urandom_range(1, 4);
            pv1 = $urandom_range(1, 4);
            ps  = $urandom_range(1, 6);
            run = '1;
            for (int c = 0; c < 100; c++) begin
                in_tdata = {$urandom, $urandom};
                in_tvalid[0] = $urandom_range(0, 3) < pv0;
                in_tvalid[1] = $urandom_range(0, 3) < pv1;
                dac_stb = $urandom_range(0, 7) < ps;
                if ($urandom_range(0, 63) == 0) begin
                    k = $urandom_range(0, NCHAN - 1);
                    run[k] = !run[k];
                end
                set_stb = 1'b0;
                r = $urandom_range(0, 199);
                if (r == 0) begin
                    set_stb = 1'b1; set_addr = 8'(BASE_A + 1);
                end else if (r < 3) begin
                    set_stb = 1'b1; set_addr = 8'(BASE_A); set_data = $urandom;
                    if ($urandom_range(0, 3) != 0) set_data[1:0] = 2'b11;
                end else if (r == 3) begin
                    set_stb = 1'b1; set_addr = 8'h07; set_data = $urandom;
                end
                step();
            end
        end
        set_stb = 1'b0; in_tvalid = '0; dac_stb = 1'b0; run = '1;

        // Counter saturation from a preloaded near-full value
        wr(8'(BASE_A), 32'h1);
        step();
        force dut.g_chan[0].u_chan.ucnt_q = 16'hFFFD;
        e_cnt[0] = 16'hFFFD;
        step();
        release dut.g_chan[0].u_chan.ucnt_q;
        uf0 = 0;
        for (int c = 0; c < 200; c++) begin
            in_tdata[31:0] = $urandom;
            in_tvalid[0] = (mmode[0] == M_PRIME);
            dac_stb = 1'b1;
            step();
            if (underflow[0]) uf0++;
        end
        chk("sat_enough_hits", uf0 >= 3, 1);
        chk("sat_count", uflow_count[15:0], 16'hFFFF);

        // Asynchronous reset in the middle of streaming
        #3 rst = 1'b1;
        #1 chk_zero("midrst");
        model_reset();
        in_tvalid = '0; dac_stb = 1'b0;
        step();
        rst = 1'b0;
        step(); step();
        chk("post_rst_idle", in_tready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/umtrx_tx_dac_mux.md
UMTRX_TX_DAC_MUX -- requirements
Module: umtrx_tx_dac_mux

Interface
REQ-001 The block SHALL have parameter NCHAN, default 2, meaning the number of independent TX channels (1..4).
REQ-002 The block SHALL have parameter DAC_WIDTH, default 12, meaning the bits per I and per Q DAC word (8..16).
REQ-003 The block SHALL have parameter DEPTH_LOG2, default 2, meaning each per-channel sample FIFO holds 2^DEPTH_LOG2 entries.
REQ-004 The block SHALL have parameter BASE, default 0, meaning the settings-bus base address.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on this clock.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have ports set_stb (input, 1), set_addr (input, 8) and set_data (input, 32): the settings bus.
REQ-008 The block SHALL have port in_tdata, input, NCHAN*32 bits: per-channel sample, I in [31:16] and Q in [15:0], channel n at [32n+31:32n].
REQ-009 The block SHALL have ports in_tvalid (input, NCHAN) and in_tready (output, NCHAN): per-channel AXI-stream handshake.
REQ-010 The block SHALL have port run, input, NCHAN bits: per-channel transmit-active level from the deframer.
REQ-011 The block SHALL have port dac_stb, input, 1 bit: the DAC sample-rate strobe.
REQ-012 The block SHALL have ports dac_i and dac_q, output, NCHAN*DAC_WIDTH bits each: registered DAC words.
REQ-013 The block SHALL have port dac_valid, output, 1 bit: a one-cycle pulse when the DAC words update.
REQ-014 The block SHALL have port underflow, output, NCHAN bits: a one-cycle per-channel underrun pulse.
REQ-015 The block SHALL have port uflow_count, output, NCHAN*16 bits: a saturating per-channel underrun counter.

Function
REQ-016 A push SHALL occur when in_tvalid[n] and in_tready[n] are both high; in_tready[n] SHALL be high only when channel n is not full and not in IDLE.
REQ-017 Each channel SHALL run a state machine with states IDLE, PRIME, RUN and UNDERRUN.
REQ-018 IDLE SHALL go to PRIME when run[n] is high and enable[n] is set.
REQ-019 PRIME SHALL go to RUN when the channel FIFO is full.
REQ-020 A RUN channel that sees dac_stb with an empty FIFO SHALL go to UNDERRUN.
REQ-021 UNDERRUN SHALL go to PRIME on the next cycle.
REQ-022 Any state SHALL go to IDLE when run[n] or enable[n] is low, and the FIFO SHALL be flushed on that same edge.
REQ-023 On dac_stb in RUN with a non-empty FIFO, the channel SHALL pop the head entry and load dac_i = I[15:16-DAC_WIDTH] and dac_q = Q[15:16-DAC_WIDTH] (truncation), visible on the cycle after dac_stb.
REQ-024 On dac_stb in IDLE, PRIME or UNDERRUN, or with an empty FIFO, the channel SHALL load zero into dac_i and dac_q.
REQ-025 dac_valid SHALL pulse exactly one cycle after every dac_stb, whatever the channel states are.
REQ-026 Underrun: dac_stb in RUN with an empty FIFO SHALL pulse underflow[n] one cycle later and increment uflow_count[n], saturating at 16'hFFFF.
REQ-027 A same-cycle push and pop SHALL leave the FIFO occupancy unchanged.
REQ-028 A push into an empty FIFO on a dac_stb cycle SHALL NOT bypass to the output; that case is an underrun.
REQ-029 The FIFO read and write pointers SHALL wrap modulo 2^DEPTH_LOG2, with a separate occupancy count so that full and empty are unambiguous.
REQ-030 Register BASE+0 SHALL hold: [NCHAN-1:0] enable, [8] swap I/Q on all channels, [9] negate Q (two's complement, -32768 maps to 32767).
REQ-031 Swap and negate SHALL be applied before truncation.
REQ-032 A write to BASE+1 SHALL clear every uflow_count; when a clear coincides with an underrun, the clear SHALL win (result 0).
REQ-033 Settings SHALL take effect on the cycle after set_stb; a dac_stb in the same cycle as a write SHALL use the old values.

Reset
REQ-034 While rst is high, every output SHALL be 0: dac_i, dac_q, dac_valid, underflow, uflow_count and in_tready.
REQ-035 Reset SHALL put every channel in IDLE, empty every FIFO and clear BASE+0 to 0.
REQ-036 Reset asserted mid-operation SHALL take effect immediately (asynchronously) and discard all FIFO contents.
REQ-037 After reset deasserts, no channel SHALL leave IDLE until enable is written.

Verification
REQ-038 Prime/run: enable=0x3, run=2'b11, push 4 samples 0x7FF0_8000 on ch0, dac_stb every 4 cycles -> ch0 in RUN after the 4th push; dac_i[11:0]=0x7FF and dac_q[11:0]=0x800 one cycle after dac_stb; dac_valid pulses.
REQ-039 Underrun: drain ch0 and keep dac_stb running -> underflow[0] pulses once, uflow_count[0]=1, dac words 0; ch0 re-primes, then streams again after 4 pushes.
REQ-040 Run drop with FIFO at 3 entries: run[0]=0 -> next cycle in_tready[0]=0 and FIFO empty; outputs 0 on the next dac_stb; no underflow pulse.
REQ-041 Settings: write BASE+0=0x301, sample 0x1234_8000 -> swap and negate give I=0x7FFF, Q=0x1234 -> dac_i=0x7FF, dac_q=0x123; a BASE+1 write coinciding with an underrun leaves the counter at 0.
REQ-042 Saturation: force 65537 underruns -> uflow_count holds 0xFFFF; an async rst pulse mid-stream -> all outputs 0 immediately and the state is IDLE.
REQ-043 Concurrency: with NCHAN=2, ch1 underruns while ch0 streams -> ch0 data is unaffected and only underflow[1] pulses.
